// File: rtl/pipe_skid_stage.sv
// ============================================================================
//  Module   : pipe_skid_stage
//  Purpose  : Valid/ready pipeline stage with a two-entry skid buffer, flush
//             to bubble, and a saturating downstream-stall counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage #(
  parameter int                         DATA_W = 32,
  parameter int                         LANES  = 3,
  parameter logic [LANES*DATA_W-1:0]    BUBBLE = '0,
  parameter int                         CNT_W  = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [LANES*DATA_W-1:0] InData,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [LANES*DATA_W-1:0] OutData,
  input  logic                    Flush,
  output logic [1:0]              Occupancy,
  output logic [CNT_W-1:0]        StallCount
);

  localparam int W = LANES * DATA_W;

  // Occupancy is the state encoding itself, so the values are fixed.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     main_q, main_d;
  logic [W-1:0]     skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic w_in_fire;
  logic w_out_fire;
  logic w_stall;

  // Ready comes from registered state only, never from OutReady, so a
  // downstream stall cannot ripple combinationally into the upstream stage.
  assign InReady    = (state_q != S_FULL) & ~Rst;
  assign OutValid   = (state_q != S_EMPTY);
  assign OutData    = main_q;
  assign Occupancy  = state_q;
  assign StallCount = stall_q;

  // OutReady is masked by OutValid so an unknown ready on an empty stage
  // cannot disturb the state.
  assign w_in_fire  = InValid & InReady;
  assign w_out_fire = OutValid & OutReady;
  assign w_stall    = OutValid & ~OutReady;

  // Next-state and data-path selection; an unknown Flush falls through to
  // the normal transitions, and unknown fire terms take the "no load" arm.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d = S_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_in_fire) begin
            state_d = S_ONE;
            main_d  = InData;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            main_d = InData;
          end else if (w_in_fire) begin
            state_d = S_FULL;
            skid_d  = InData;
          end else if (w_out_fire) begin
            state_d = S_EMPTY;
            main_d  = BUBBLE;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // Stall counter saturates at all-ones and ignores Flush.
  always_comb begin
    stall_d = stall_q;
    if (w_stall && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stage state, payload registers and stall counter; reset clears at once.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// ============================================================================
//  Module   : tb_pipe_skid_stage
//  Purpose  : Self-checking bench for pipe_skid_stage: directed scenarios on
//             a 3x32 instance, saturation and random traffic on a 1x8 one.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_stage;

  logic clk;
  int   n_chk  = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: 3 lanes x 32 bits, 16-bit counter --------
  logic        a_rst, a_InValid, a_InReady, a_OutValid, a_OutReady, a_Flush;
  logic [95:0] a_InData, a_OutData;
  logic [1:0]  a_Occupancy;
  logic [15:0] a_StallCount;

  pipe_skid_stage u_a (
    .Clk(clk), .Rst(a_rst),
    .InValid(a_InValid), .InReady(a_InReady), .InData(a_InData),
    .OutValid(a_OutValid), .OutReady(a_OutReady), .OutData(a_OutData),
    .Flush(a_Flush), .Occupancy(a_Occupancy), .StallCount(a_StallCount)
  );

  // ---------------- instance B: 1 lane x 8 bits, 4-bit counter -----------
  logic       b_rst, b_InValid, b_InReady, b_OutValid, b_OutReady, b_Flush;
  logic [7:0] b_InData, b_OutData;
  logic [1:0] b_Occupancy;
  logic [3:0] b_StallCount;

  pipe_skid_stage #(.DATA_W(8), .LANES(1), .BUBBLE(8'h00), .CNT_W(4)) u_b (
    .Clk(clk), .Rst(b_rst),
    .InValid(b_InValid), .InReady(b_InReady), .InData(b_InData),
    .OutValid(b_OutValid), .OutReady(b_OutReady), .OutData(b_OutData),
    .Flush(b_Flush), .Occupancy(b_Occupancy), .StallCount(b_StallCount)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard models ------------------------------------
  // Queue contents are the entries the stage should be holding, front first;
  // its size is the expected occupancy.
  logic [95:0] aq[$];
  int          a_cnt;
  logic [7:0]  bq[$];
  int          b_cnt;

  // Compare A against its model on the falling edge, then advance the model
  // using the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    logic inf, outf;
    if (a_rst) begin
      aq.delete();
      a_cnt = 0;
    end
    check("a_occ",   {126'd0, a_Occupancy}, aq.size());
    check("a_oval",  a_OutValid, aq.size() != 0);
    check("a_irdy",  a_InReady, (aq.size() < 2) && !a_rst);
    check("a_stall", a_StallCount, a_cnt);
    check("a_odata", a_OutData, (aq.size() != 0) ? aq[0] : 96'd0);
    if (!a_rst) begin
      outf = (aq.size() != 0) && a_OutReady;
      inf  = a_InValid && (aq.size() < 2);
      if ((aq.size() != 0) && !a_OutReady && a_cnt < 65535) a_cnt++;
      if (outf) void'(aq.pop_front());
      if (a_Flush) aq.delete();
      else if (inf) aq.push_back(a_InData);
    end
  end

  always @(negedge clk) begin
    logic inf, outf;
    if (b_rst) begin
      bq.delete();
      b_cnt = 0;
    end
    check("b_occ",   {126'd0, b_Occupancy}, bq.size());
    check("b_occmax", b_Occupancy <= 2'd2, 1'b1);
    check("b_oval",  b_OutValid, bq.size() != 0);
    check("b_irdy",  b_InReady, (bq.size() < 2) && !b_rst);
    check("b_stall", b_StallCount, b_cnt);
    check("b_odata", b_OutData, (bq.size() != 0) ? bq[0] : 8'd0);
    if (!b_rst) begin
      outf = (bq.size() != 0) && b_OutReady;
      inf  = b_InValid && (bq.size() < 2);
      if ((bq.size() != 0) && !b_OutReady && b_cnt < 15) b_cnt++;
      if (outf) void'(bq.pop_front());
      if (b_Flush) bq.delete();
      else if (inf) bq.push_back(b_InData);
    end
  end

  // ---------------- stimulus ----------------------------------------------
  initial begin
    a_rst = 1'b1; a_InValid = 1'b0; a_OutReady = 1'b0; a_Flush = 1'b0; a_InData = '0;
    b_rst = 1'b1; b_InValid = 1'b0; b_OutReady = 1'b0; b_Flush = 1'b0; b_InData = '0;
    tick(); tick();
    check("rst_oval",  a_OutValid, 1'b0);
    check("rst_irdy",  a_InReady, 1'b0);
    check("rst_occ",   a_Occupancy, 2'd0);
    check("rst_stall", a_StallCount, 16'd0);

    // Stream 1..5 with downstream always ready: one-cycle latency, no stall.
    a_rst = 1'b0; a_InValid = 1'b1; a_OutReady = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      a_InData = 96'(k);
      tick();
      check("stream_data", a_OutData, 96'(k));
      check("stream_occ",  a_Occupancy, 2'd1);
      check("stream_irdy", a_InReady, 1'b1);
    end
    check("stream_stall", a_StallCount, 16'd0);
    a_InValid = 1'b0;
    tick();

    // Backpressure: A held, B goes to skid, then both drain in order.
    a_OutReady = 1'b0; a_InValid = 1'b1; a_InData = 96'hAAAA_0000_0000_0000_0000_000A;
    tick();
    a_InData = 96'hBBBB_0000_0000_0000_0000_000B;
    tick();
    check("bp_occ2",  a_Occupancy, 2'd2);
    check("bp_irdy0", a_InReady, 1'b0);
    check("bp_dataA", a_OutData, 96'hAAAA_0000_0000_0000_0000_000A);
    a_InValid = 1'b0; a_OutReady = 1'b1;
    tick();
    check("bp_dataB", a_OutData, 96'hBBBB_0000_0000_0000_0000_000B);
    check("bp_occ1",  a_Occupancy, 2'd1);
    tick();
    check("bp_occ0",  a_Occupancy, 2'd0);

    // Flush while FULL with a word offered: the offered word must vanish.
    a_OutReady = 1'b0; a_InValid = 1'b1; a_InData = 96'hD1;
    tick();
    a_InData = 96'hD2;
    tick();
    a_InData = 96'hD3; a_Flush = 1'b1;
    tick();
    a_Flush = 1'b0; a_InValid = 1'b0; a_OutReady = 1'b1;
    check("fl_oval", a_OutValid, 1'b0);
    check("fl_occ",  a_Occupancy, 2'd0);
    check("fl_data", a_OutData, 96'd0);
    tick(); tick();
    check("fl_gone", a_OutValid, 1'b0);

    // Flush in ONE with a concurrent accept and a concurrent delivery.
    a_InValid = 1'b1; a_InData = 96'hE1;
    tick();
    a_InData = 96'hE2; a_Flush = 1'b1;
    tick();
    a_Flush = 1'b0; a_InValid = 1'b0;
    check("fl1_occ", a_Occupancy, 2'd0);

    // Stall counter: fresh reset, one word, 10 stalled cycles.
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0; a_InValid = 1'b1; a_OutReady = 1'b0; a_InData = 96'h77;
    tick();
    a_InValid = 1'b0;
    repeat (10) tick();
    check("stall10", a_StallCount, 16'd10);

    // Async reset while FULL, observed before the next clock edge.
    a_InValid = 1'b1; a_InData = 96'h88;
    tick();
    a_InValid = 1'b0;
    check("ar_full", a_Occupancy, 2'd2);
    #2 a_rst = 1'b1;
    #1;
    check("ar_oval",  a_OutValid, 1'b0);
    check("ar_irdy",  a_InReady, 1'b0);
    check("ar_stall", a_StallCount, 16'd0);
    check("ar_occ",   a_Occupancy, 2'd0);
    tick();
    a_rst = 1'b0;

    // B: 4-bit counter saturation after 20 stalled cycles.
    b_rst = 1'b0; b_InValid = 1'b1; b_OutReady = 1'b0; b_InData = 8'h5A;
    tick();
    b_InValid = 1'b0;
    repeat (20) tick();
    check("sat15", b_StallCount, 4'd15);
    check("sat_data", b_OutData, 8'h5A);
    b_OutReady = 1'b1;
    tick();

    // B: random valid/ready/flush traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      b_InValid  = 1'($urandom_range(0, 1));
      b_OutReady = ($urandom_range(0, 3) != 0);
      b_InData   = 8'($urandom);
      b_Flush    = ($urandom_range(0, 63) == 0);
      tick();
    end
    b_InValid = 1'b0; b_Flush = 1'b0; b_OutReady = 1'b1;
    repeat (3) tick();
    check("b_drain", b_Occupancy, 2'd0);

    #10;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
